// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data bus between the memory stage and the memory system
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store memory stage with lane steering, faults and bus timeout
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_noop,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_mem_rd,
  output logic        out_fault,
  output logic [1:0]  out_fault_cause,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] out_mem_rd_q, out_mem_rd_d;
  logic        out_fault_q, out_fault_d;
  logic [1:0]  out_fault_cause_q, out_fault_cause_d;

  logic is_load, is_store, accept, illegal, misaligned;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;

  // Decode: which instructions we take, and whether they fault before touching the bus
  always_comb begin
    is_load    = (in_opcode == OP_LOAD);
    is_store   = (in_opcode == OP_STORE);
    accept     = (state_q == IDLE) && in_valid && !in_noop && (is_load || is_store);
    illegal    = is_store ? (in_funct3 >= 3'd3)
                          : (in_funct3 == 3'd3 || in_funct3 == 3'd6 || in_funct3 == 3'd7);
    misaligned = !illegal &&
                 (((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                  ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));
    st_wstrb   = 4'b0000;
    st_wdata   = 32'h0;
    if (is_store) begin
      case (in_funct3[1:0])
        2'b00:   begin st_wstrb = 4'b0001 << in_addr[1:0]; st_wdata = {4{in_store_data[7:0]}};  end
        2'b01:   begin st_wstrb = 4'b0011 << in_addr[1:0]; st_wdata = {2{in_store_data[15:0]}}; end
        default: begin st_wstrb = 4'b1111;                 st_wdata = in_store_data;            end
      endcase
    end
  end

  // Next-state and registered-output logic for the IDLE/REQ/DONE sequencer
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    off_d             = off_q;
    bus_req_d         = bus_req_q;
    bus_we_d          = bus_we_q;
    bus_addr_d        = bus_addr_q;
    bus_wstrb_d       = bus_wstrb_q;
    bus_wdata_d       = bus_wdata_q;
    out_mem_rd_d      = out_mem_rd_q;
    out_fault_d       = out_fault_q;
    out_fault_cause_d = out_fault_cause_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal || misaligned) begin
            state_d           = DONE;
            out_fault_d       = 1'b1;
            out_fault_cause_d = illegal ? 2'd2 : 2'd1;
            out_mem_rd_d      = 32'h0;
          end else begin
            state_d     = REQ;
            cnt_d       = 8'd0;
            off_d       = in_addr[1:0];
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_addr_d  = {in_addr[31:2], 2'b00};
            bus_wstrb_d = st_wstrb;
            bus_wdata_d = st_wdata;
          end
        end
      end
      REQ: begin
        if (bus.bus_ack || (cnt_q == CNT_LAST)) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 32'h0;
          bus_wstrb_d = 4'b0000;
          bus_wdata_d = 32'h0;
          if (bus.bus_ack) begin
            out_fault_d       = 1'b0;
            out_fault_cause_d = 2'd0;
            out_mem_rd_d      = bus_we_q ? 32'h0 : (bus.bus_rdata >> {off_q, 3'b000});
          end else begin
            out_fault_d       = 1'b1;
            out_fault_cause_d = 2'd3;
            out_mem_rd_d      = 32'h0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d           = IDLE;
        out_fault_d       = 1'b0;
        out_fault_cause_d = 2'd0;
        out_mem_rd_d      = 32'h0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      cnt_q             <= 8'd0;
      off_q             <= 2'd0;
      bus_req_q         <= 1'b0;
      bus_we_q          <= 1'b0;
      bus_addr_q        <= 32'h0;
      bus_wstrb_q       <= 4'b0000;
      bus_wdata_q       <= 32'h0;
      out_mem_rd_q      <= 32'h0;
      out_fault_q       <= 1'b0;
      out_fault_cause_q <= 2'd0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      off_q             <= off_d;
      bus_req_q         <= bus_req_d;
      bus_we_q          <= bus_we_d;
      bus_addr_q        <= bus_addr_d;
      bus_wstrb_q       <= bus_wstrb_d;
      bus_wdata_q       <= bus_wdata_d;
      out_mem_rd_q      <= out_mem_rd_d;
      out_fault_q       <= out_fault_d;
      out_fault_cause_q <= out_fault_cause_d;
    end
  end

  // Output wiring: stall covers the accept cycle and the whole bus phase
  always_comb begin
    stall           = accept || (state_q == REQ);
    out_valid       = (state_q == DONE);
    out_mem_rd      = out_mem_rd_q;
    out_fault       = out_fault_q;
    out_fault_cause = out_fault_cause_q;
    bus.bus_req     = bus_req_q;
    bus.bus_we      = bus_we_q;
    bus.bus_addr    = bus_addr_q;
    bus.bus_wstrb   = bus_wstrb_q;
    bus.bus_wdata   = bus_wdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
  localparam int TO = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_noop;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_store_data;
  logic        stall, out_valid, out_fault;
  logic [31:0] out_mem_rd;
  logic [1:0]  out_fault_cause;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_noop(in_noop), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data),
    .stall(stall), .out_valid(out_valid), .out_mem_rd(out_mem_rd),
    .out_fault(out_fault), .out_fault_cause(out_fault_cause),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  // Reference: what an access should do, from the instruction semantics alone
  function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] rdata,
                                output logic flt, output logic [1:0] cause,
                                output logic [3:0] strb, output logic [31:0] wd,
                                output logic [31:0] rd);
    bit st = (op == OP_STORE);
    bit legal;
    int size, off;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << (int'(f3) % 4);
    off   = int'(addr % 4);
    flt = 1'b0; cause = 2'd0; strb = 4'b0; wd = 32'h0; rd = 32'h0;
    if (!legal) begin flt = 1'b1; cause = 2'd2; end
    else if ((off % size) != 0) begin flt = 1'b1; cause = 2'd1; end
    if (!flt && st) begin
      for (int i = 0; i < size; i++) strb[off + i] = 1'b1;
      for (int j = 0; j < 4; j++) wd[8*j +: 8] = sd[8*(j % size) +: 8];
    end
    if (!flt && !st) rd = rdata >> (8 * off);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_noop = 0; in_opcode = 0; in_funct3 = 0; in_addr = 0; in_store_data = 0;
    bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({stall, out_valid, out_mem_rd, out_fault, out_fault_cause} !== 37'h0) begin
      n_fail++; $display("FAIL reset_out: got stall=%b v=%b rd=%h f=%b c=%0d want all 0",
                         stall, out_valid, out_mem_rd, out_fault, out_fault_cause);
    end
    n_tests++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata} !== 70'h0) begin
      n_fail++; $display("FAIL reset_bus: got req=%b we=%b addr=%h strb=%b wd=%h want all 0",
                         bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One accepted instruction; ack_lat = REQ cycle carrying bus_ack (beyond TO means never)
  task automatic run_txn(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input int ack_lat, input logic [31:0] rdata);
    logic e_flt; logic [1:0] e_cause; logic [3:0] e_strb; logic [31:0] e_wd, e_rd;
    logic e_we;
    int e_edges, e_nreq, edges, nreq;
    bit got, bus_bad, stall_bad, done_stall;
    logic [31:0] g_rd; logic g_flt; logic [1:0] g_cause;
    model(op, f3, addr, sd, rdata, e_flt, e_cause, e_strb, e_wd, e_rd);
    e_we = (op == OP_STORE);
    if (e_flt) begin e_edges = 1; e_nreq = 0; end
    else if (ack_lat >= 1 && ack_lat <= TO) begin e_edges = ack_lat + 1; e_nreq = ack_lat; end
    else begin e_edges = TO + 1; e_nreq = TO; e_flt = 1'b1; e_cause = 2'd3; e_rd = 32'h0; end

    in_valid = 1; in_noop = 0; in_opcode = op; in_funct3 = f3; in_addr = addr; in_store_data = sd;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL %s accept_stall: got %b want 1", name, stall); end

    edges = 0; nreq = 0; got = 0; bus_bad = 0; stall_bad = 0; done_stall = 0;
    g_rd = 0; g_flt = 0; g_cause = 0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (bus_if.bus_req === 1'b1) begin
        nreq++;
        if (bus_if.bus_addr !== {addr[31:2], 2'b00} || bus_if.bus_we !== e_we ||
            bus_if.bus_wstrb !== e_strb || bus_if.bus_wdata !== e_wd) begin
          if (!bus_bad) $display("  %s bus got addr=%h we=%b strb=%b wd=%h want %h %b %b %h", name,
                                 bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_wdata,
                                 {addr[31:2], 2'b00}, e_we, e_strb, e_wd);
          bus_bad = 1;
        end
        bus_if.bus_ack   = (nreq == ack_lat);
        bus_if.bus_rdata = (nreq == ack_lat) ? rdata : $urandom;
      end else begin
        bus_if.bus_ack = 0;
      end
      if (out_valid === 1'b1) begin
        got = 1; g_rd = out_mem_rd; g_flt = out_fault; g_cause = out_fault_cause;
        done_stall = stall; in_valid = 0; bus_if.bus_ack = 0;
      end else if (stall !== 1'b1) begin
        stall_bad = 1;
      end
    end
    in_valid = 0;
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL %s no_out_valid: got none in %0d cycles want 1 pulse", name, edges); end
    n_tests++;
    if (edges != e_edges) begin n_fail++; $display("FAIL %s latency: got %0d edges want %0d", name, edges, e_edges); end
    n_tests++;
    if (nreq != e_nreq) begin n_fail++; $display("FAIL %s req_cycles: got %0d want %0d", name, nreq, e_nreq); end
    n_tests++;
    if (bus_bad) begin n_fail++; $display("FAIL %s bus_fields: got mismatching bus outputs want model values", name); end
    n_tests++;
    if (g_flt !== e_flt || g_cause !== e_cause) begin
      n_fail++; $display("FAIL %s fault: got %b/%0d want %b/%0d", name, g_flt, g_cause, e_flt, e_cause);
    end
    n_tests++;
    if (g_rd !== e_rd) begin n_fail++; $display("FAIL %s mem_rd: got %h want %h", name, g_rd, e_rd); end
    n_tests++;
    if (stall_bad || done_stall !== 1'b0) begin
      n_fail++; $display("FAIL %s stall: got busy_low=%b done=%b want 0 0", name, stall_bad, done_stall);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s pulse_width: got out_valid %b want 0", name, out_valid); end
  endtask

  task automatic test_directed();
    run_txn("lbu_1003", OP_LOAD, 3'd4, 32'h1003, 32'h0, 2, 32'hAABBCCDD);
    run_txn("sh_2002", OP_STORE, 3'd1, 32'h2002, 32'h0000BEEF, 1, 32'h0);
    run_txn("lw_mis", OP_LOAD, 3'd2, 32'h3001, 32'h0, 1, 32'h12345678);
    run_txn("ld_f3_3", OP_LOAD, 3'd3, 32'h3000, 32'h0, 1, 32'h12345678);
    run_txn("sw_f3_5", OP_STORE, 3'd5, 32'h3004, 32'h1, 1, 32'h0);
    run_txn("sb_3", OP_STORE, 3'd0, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0);
    run_txn("lh_2", OP_LOAD, 3'd1, 32'h0000_0202, 32'h0, 3, 32'h8765_4321);
  endtask

  task automatic test_timeout();
    run_txn("timeout", OP_LOAD, 3'd2, 32'h6000, 32'h0, 0, 32'h0);
    run_txn("ack_last", OP_LOAD, 3'd2, 32'h6004, 32'h0, TO, 32'hCAFEF00D);
  endtask

  task automatic test_no_accept();
    logic [6:0] ops [3] = '{OP_LOAD, OP_STORE, 7'b0110011};
    logic       vld [3] = '{1'b1, 1'b0, 1'b1};
    logic       nop [3] = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      bit bad = 0;
      in_valid = vld[k]; in_noop = nop[k]; in_opcode = ops[k]; in_funct3 = 3'd2; in_addr = 32'h40;
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hFFFF_FFFF;
      #1;
      for (int c = 0; c < 3; c++) begin
        if (stall !== 1'b0 || out_valid !== 1'b0 || bus_if.bus_req !== 1'b0) bad = 1;
        @(posedge clk); #1;
      end
      n_tests++;
      if (bad) begin n_fail++; $display("FAIL no_accept_%0d: got activity (stall/valid/req) want none", k); end
    end
    in_valid = 0; in_noop = 0; bus_if.bus_ack = 0;
  endtask

  task automatic test_reset_mid_req();
    int waited = 0;
    bit seen_valid = 0;
    in_valid = 1; in_noop = 0; in_opcode = OP_LOAD; in_funct3 = 3'd2; in_addr = 32'h5000;
    bus_if.bus_ack = 0;
    while (bus_if.bus_req !== 1'b1 && waited < 10) begin @(posedge clk); #1; waited++; end
    @(posedge clk); #1;
    rst_n = 0; in_valid = 0;
    #1;
    n_tests++;
    if (bus_if.bus_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_req: got req=%b valid=%b want 0 0 (waited %0d)", bus_if.bus_req, out_valid, waited);
    end
    @(posedge clk); #1;
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      if (out_valid !== 1'b0 || bus_if.bus_req !== 1'b0) seen_valid = 1;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen_valid) begin n_fail++; $display("FAIL rst_after: got activity after reset want none"); end
    run_txn("sw_4000", OP_STORE, 3'd2, 32'h4000, 32'h1357_9BDF, 1, 32'h0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [6:0] op;
      logic [2:0] f3;
      int lat;
      op  = $urandom_range(0, 1) ? OP_STORE : OP_LOAD;
      f3  = 3'($urandom_range(0, 7));
      lat = $urandom_range(1, TO + 1);
      run_txn($sformatf("rnd%0d", t), op, f3, $urandom, $urandom, lat, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_no_accept();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
